// File: rtl/ctrl_pipeline.sv
// Control-word pipeline from decode through writeback, with NZCV flags.
// Condition result gates every state-changing bit in Execute.
module ctrl_pipeline #(
  parameter logic [3:0] FLAGS_RST = 4'b0000,
  parameter int         COND_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COND_W-1:0] CondD,
  input  logic              PCSD,
  input  logic              RegWD,
  input  logic              MemWD,
  input  logic              MemtoRegD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ALUControlD,
  input  logic [1:0]        FlagWD,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [3:0]        ALUFlags,
  input  logic              CondExE,
  output logic [COND_W-1:0] CondE,
  output logic [3:0]        FlagsE,
  output logic              ALUSrcE,
  output logic [1:0]        ALUControlE,
  output logic              MemtoRegE,
  output logic              BranchTakenE,
  output logic              PCSrcE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              MemtoRegM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic              PCSrcW
);

  typedef struct packed {
    logic [COND_W-1:0] cond;
    logic              pcs;
    logic              regw;
    logic              memw;
    logic              memtoreg;
    logic              branch;
    logic              alusrc;
    logic [1:0]        aluctrl;
    logic [1:0]        flagw;
    logic              valid;
  } id_ex_t;

  typedef struct packed {
    logic regw;
    logic memw;
    logic memtoreg;
    logic pcsrc;
  } ex_mem_t;

  typedef struct packed {
    logic regw;
    logic memtoreg;
    logic pcsrc;
  } mem_wb_t;

  id_ex_t  dec;
  id_ex_t  ex_q;
  ex_mem_t ex_res;
  ex_mem_t mem_q;
  mem_wb_t wb_q;
  logic [3:0] flags_q;
  logic       gate;
  logic [1:0] flag_we;

  always_comb begin
    dec          = '0;
    dec.cond     = CondD;
    dec.pcs      = PCSD;
    dec.regw     = RegWD;
    dec.memw     = MemWD;
    dec.memtoreg = MemtoRegD;
    dec.branch   = BranchD;
    dec.alusrc   = ALUSrcD;
    dec.aluctrl  = ALUControlD;
    dec.flagw    = FlagWD;
    dec.valid    = 1'b1;
  end

  // A bubble (valid=0) must never write, whatever its condition says.
  assign gate    = CondExE & ex_q.valid;
  assign flag_we = ex_q.flagw & {2{gate}};

  always_comb begin
    ex_res          = '0;
    ex_res.regw     = ex_q.regw & gate;
    ex_res.memw     = ex_q.memw & gate;
    ex_res.memtoreg = ex_q.memtoreg;
    ex_res.pcsrc    = ex_q.pcs & gate;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else if (FlushE) begin
      ex_q <= '0;
    end else if (!StallE) begin
      ex_q <= dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || StallE) begin
      mem_q <= '0;
    end else begin
      mem_q <= ex_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q <= '0;
    end else begin
      wb_q.regw     <= mem_q.regw;
      wb_q.memtoreg <= mem_q.memtoreg;
      wb_q.pcsrc    <= mem_q.pcsrc;
    end
  end

  // Flags commit only in the cycle the instruction leaves Execute.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAGS_RST;
    end else if (!StallE) begin
      if (flag_we[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_we[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign CondE        = ex_q.cond;
  assign FlagsE       = flags_q;
  assign ALUSrcE      = ex_q.alusrc;
  assign ALUControlE  = ex_q.aluctrl;
  assign MemtoRegE    = ex_q.memtoreg;
  assign BranchTakenE = ex_q.branch & gate;
  assign PCSrcE       = ex_res.pcsrc;
  assign RegWriteM    = mem_q.regw;
  assign MemWriteM    = mem_q.memw;
  assign MemtoRegM    = mem_q.memtoreg;
  assign RegWriteW    = wb_q.regw;
  assign MemtoRegW    = wb_q.memtoreg;
  assign PCSrcW       = wb_q.pcsrc;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed scenarios plus random traffic
// compared against an instruction-level reference model.
module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] CondD;
  logic       PCSD, RegWD, MemWD, MemtoRegD, BranchD, ALUSrcD;
  logic [1:0] ALUControlD, FlagWD;
  logic       StallE, FlushE;
  logic [3:0] ALUFlags;
  logic       CondExE;
  logic [3:0] CondE, FlagsE;
  logic       ALUSrcE, MemtoRegE, BranchTakenE, PCSrcE;
  logic [1:0] ALUControlE;
  logic       RegWriteM, MemWriteM, MemtoRegM;
  logic       RegWriteW, MemtoRegW, PCSrcW;

  ctrl_pipeline dut (
    .clk(clk), .reset(reset), .CondD(CondD), .PCSD(PCSD),
    .RegWD(RegWD), .MemWD(MemWD), .MemtoRegD(MemtoRegD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .FlagWD(FlagWD), .StallE(StallE), .FlushE(FlushE),
    .ALUFlags(ALUFlags), .CondExE(CondExE), .CondE(CondE),
    .FlagsE(FlagsE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
    .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .MemtoRegM(MemtoRegM), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [19:0] obs;
  assign obs = {CondE, FlagsE, ALUSrcE, ALUControlE, MemtoRegE,
                BranchTakenE, PCSrcE, RegWriteM, MemWriteM, MemtoRegM,
                RegWriteW, MemtoRegW, PCSrcW};

  // Reference model: the instruction sitting in Execute and the
  // write-effects records retired into Memory and Writeback.
  typedef struct packed {
    logic       v;
    logic [3:0] cond;
    logic       pcs, rw, mw, m2r, br, src;
    logic [1:0] alu, fw;
  } ins_t;

  typedef struct packed {
    logic rw, mw, m2r, pc;
  } ent_t;

  ins_t       me;
  ent_t       mm, mwb;
  logic [3:0] mf;

  function automatic logic [19:0] expect_out();
    logic go;
    go = me.v && CondExE;
    return {me.cond, mf, me.src, me.alu, me.m2r, me.br & go,
            me.pcs & go, mm.rw, mm.mw, mm.m2r, mwb.rw, mwb.m2r, mwb.pc};
  endfunction

  task automatic cyc();
    logic       go;
    logic [3:0] mask;
    @(posedge clk);
    if (reset) begin
      me = '0; mm = '0; mwb = '0; mf = 4'b0000;
    end else begin
      go = me.v && CondExE;
      if (!StallE && go) begin
        mask = {me.fw[1], me.fw[1], me.fw[0], me.fw[0]};
        mf = (mf & ~mask) | (ALUFlags & mask);
      end
      mwb = mm;
      if (StallE) mm = '0;
      else mm = '{rw: me.rw & go, mw: me.mw & go,
                  m2r: me.m2r, pc: me.pcs & go};
      if (FlushE) me = '0;
      else if (!StallE)
        me = '{v: 1'b1, cond: CondD, pcs: PCSD, rw: RegWD, mw: MemWD,
               m2r: MemtoRegD, br: BranchD, src: ALUSrcD,
               alu: ALUControlD, fw: FlagWD};
    end
    #1;
  endtask

  task automatic idle();
    CondD = 4'h0; PCSD = 0; RegWD = 0; MemWD = 0; MemtoRegD = 0;
    BranchD = 0; ALUSrcD = 0; ALUControlD = 2'b00; FlagWD = 2'b00;
    StallE = 0; FlushE = 0; ALUFlags = 4'h0; CondExE = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_init got %h exp 00000", obs);
    end
    CondD = 4'hE; RegWD = 1; CondExE = 1;
    cyc();
    cyc();
    #1;
    checks++;
    if (RegWriteM !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_regwm got %b exp 1", RegWriteM);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid got %h exp 00000", obs);
    end
  endtask

  task automatic test_cond_pass();
    do_reset();
    CondD = 4'hE; RegWD = 1; CondExE = 1;
    cyc();
    idle();
    CondExE = 1;
    #1;
    checks++;
    if (CondE !== 4'hE) begin
      errors++;
      $display("FAIL pass_conde got %h exp e", CondE);
    end
    cyc();
    #1;
    checks++;
    if (RegWriteM !== 1'b1) begin
      errors++;
      $display("FAIL pass_regwm got %b exp 1", RegWriteM);
    end
    cyc();
    #1;
    checks++;
    if (RegWriteW !== 1'b1) begin
      errors++;
      $display("FAIL pass_regww got %b exp 1", RegWriteW);
    end
  endtask

  task automatic test_cond_fail();
    do_reset();
    CondD = 4'h0; MemWD = 1; BranchD = 1; CondExE = 0;
    cyc();
    idle();
    #1;
    checks++;
    if (BranchTakenE !== 1'b0) begin
      errors++;
      $display("FAIL fail_brtaken got %b exp 0", BranchTakenE);
    end
    CondExE = 1;
    #1;
    checks++;
    if (BranchTakenE !== 1'b1) begin
      errors++;
      $display("FAIL pass_brtaken got %b exp 1", BranchTakenE);
    end
    CondExE = 0;
    cyc();
    #1;
    checks++;
    if (MemWriteM !== 1'b0) begin
      errors++;
      $display("FAIL fail_memwm got %b exp 0", MemWriteM);
    end
  endtask

  task automatic test_flags_partial();
    do_reset();
    FlagWD = 2'b10; ALUFlags = 4'b0111; CondExE = 1;
    cyc();
    #1;
    checks++;
    if (FlagsE !== 4'b0000) begin
      errors++;
      $display("FAIL flags_start got %b exp 0000", FlagsE);
    end
    FlagWD = 2'b01;
    cyc();
    ALUFlags = 4'b1011;
    #1;
    checks++;
    if (FlagsE !== 4'b0100) begin
      errors++;
      $display("FAIL flags_nz got %b exp 0100", FlagsE);
    end
    FlagWD = 2'b00;
    cyc();
    #1;
    checks++;
    if (FlagsE !== 4'b0111) begin
      errors++;
      $display("FAIL flags_cv got %b exp 0111", FlagsE);
    end
  endtask

  task automatic test_stall();
    do_reset();
    CondD = 4'hA; RegWD = 1; FlagWD = 2'b11; ALUControlD = 2'b10;
    ALUSrcD = 1; CondExE = 1; ALUFlags = 4'b1010;
    cyc();
    idle();
    ALUControlD = 2'b01; CondExE = 1; ALUFlags = 4'b1010; StallE = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      checks++;
      if ({CondE, ALUControlE, ALUSrcE} !== {4'hA, 2'b10, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold%0d got %h/%b/%b exp a/10/1",
                 i, CondE, ALUControlE, ALUSrcE);
      end
      checks++;
      if ({RegWriteM, FlagsE} !== 5'b0_0000) begin
        errors++;
        $display("FAIL stall_m%0d got regwm %b flags %b exp 0 0000",
                 i, RegWriteM, FlagsE);
      end
    end
    StallE = 0;
    ALUControlD = 2'b00;
    cyc();
    ALUFlags = 4'b0101;
    #1;
    checks++;
    if ({RegWriteM, FlagsE} !== 5'b1_1010) begin
      errors++;
      $display("FAIL stall_release got regwm %b flags %b exp 1 1010",
               RegWriteM, FlagsE);
    end
    cyc();
    #1;
    checks++;
    if (FlagsE !== 4'b1010) begin
      errors++;
      $display("FAIL stall_once got %b exp 1010", FlagsE);
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    CondD = 4'hF; RegWD = 1; PCSD = 1; BranchD = 1; ALUControlD = 2'b11;
    cyc();
    FlushE = 1; StallE = 1; CondExE = 1;
    cyc();
    #1;
    checks++;
    if ({ALUControlE, CondE, PCSrcE, BranchTakenE, RegWriteM} !== 9'h0) begin
      errors++;
      $display("FAIL flush_stall got alu %b cond %h pc %b br %b rwm %b exp 0",
               ALUControlE, CondE, PCSrcE, BranchTakenE, RegWriteM);
    end
    idle();
  endtask

  task automatic test_random();
    logic [19:0] exp_v;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 40) == 0);
      StallE      = ($urandom_range(0, 4) == 0);
      FlushE      = ($urandom_range(0, 5) == 0);
      CondD       = 4'($urandom);
      PCSD        = 1'($urandom);
      RegWD       = 1'($urandom);
      MemWD       = 1'($urandom);
      MemtoRegD   = 1'($urandom);
      BranchD     = 1'($urandom);
      ALUSrcD     = 1'($urandom);
      ALUControlD = 2'($urandom);
      FlagWD      = 2'($urandom);
      ALUFlags    = 4'($urandom);
      CondExE     = 1'($urandom);
      #3;
      exp_v = expect_out();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rand_%0d got %h exp %h", n, obs, exp_v);
      end
      cyc();
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_cond_pass();
    test_cond_fail();
    test_flags_partial();
    test_stall();
    test_flush_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Control-signal pipeline for the CPU core. Registers the decode-stage control word from the controller into the Execute, Memory and Writeback stages.
- Owns the architectural NZCV flags register, which it drives back to the condition checker as the Execute-stage flags.
- Consumes the condition result (CondExE) to gate every state-changing control bit.
- Sits between the controller/decoder (upstream) and the datapath plus hazard unit (downstream).

Parameters:
FLAGS_RST, 4'b0000, reset value of the NZCV flags register (bit3=N, bit2=Z, bit1=C, bit0=V)
COND_W, 4, width of the condition field

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all stage registers and flags
CondD  in  COND_W  condition field of the decode-stage instruction (InstrD[31:28])
PCSD  in  1  decode: instruction writes PC
RegWD  in  1  decode: register-file write
MemWD  in  1  decode: memory write
MemtoRegD  in  1  decode: writeback selects memory data
BranchD  in  1  decode: branch instruction
ALUSrcD  in  1  decode: ALU operand-B select
ALUControlD  in  2  decode: ALU operation
FlagWD  in  2  decode: [1] update N,Z; [0] update C,V
StallE  in  1  hazard unit: hold Execute stage
FlushE  in  1  hazard unit: replace Execute stage with bubble
ALUFlags  in  4  NZCV produced by ALU this cycle (Execute)
CondExE  in  1  condition-check result for the Execute instruction
CondE  out  COND_W  Execute-stage condition field, to condition checker
FlagsE  out  4  current flags register, to condition checker
ALUSrcE  out  1  Execute ALU operand-B select
ALUControlE  out  2  Execute ALU operation
MemtoRegE  out  1  Execute load indicator, to hazard unit
BranchTakenE  out  1  BranchE & CondExE & ValidE
PCSrcE  out  1  PCSE & CondExE & ValidE (not branch)
RegWriteM  out  1  Memory-stage gated register write
MemWriteM  out  1  Memory-stage gated memory write
MemtoRegM  out  1  Memory-stage writeback select
RegWriteW  out  1  Writeback-stage gated register write
MemtoRegW  out  1  Writeback-stage writeback select
PCSrcW  out  1  Writeback-stage gated PC write

Behaviour:
- Reset (sync, reset=1 at edge): all E/M/W registers cleared, so every output above reads 0; ValidE=ValidM=ValidW=0; flags register = FLAGS_RST. Reset overrides stall and flush.
- D->E register, each edge:
  - FlushE=1: E loads a bubble (all control 0, CondE=0, ValidE=0). FlushE has priority over StallE.
  - StallE=1 and FlushE=0: E holds its value.
  - Otherwise: E loads the D inputs and sets ValidE=1.
- Gating, combinational in Execute:
  - Gate = CondExE & ValidE.
  - RegWriteE' = RegWE & Gate; MemWriteE' = MemWE & Gate; PCSrcE = PCSE & Gate; BranchTakenE = BranchE & Gate.
  - FlagWriteE[1:0] = FlagWE & {2{Gate}}.
- E->M register, each edge:
  - StallE=1: M loads a bubble (the held instruction does not advance).
  - Otherwise: M loads RegWriteE', MemWriteE', MemtoRegE, PCSrcE.
- M->W register: always loads M, no stall or flush.
- Flags register:
  - On an edge with StallE=0: if FlagWriteE[1], N,Z <= ALUFlags[3:2]; if FlagWriteE[0], C,V <= ALUFlags[1:0].
  - While StallE=1: no flag update (update happens once, in the advancing cycle).
  - FlagsE always shows the register. A following dependent instruction sees new flags in its Execute cycle, one cycle after the update.
- Latency: D inputs appear at E outputs 1 cycle later, at M outputs 2 cycles later, at W outputs 3 cycles later.
- An instruction failing its condition propagates as an M/W entry with all writes 0.
- CondE of a bubble is 0 (EQ), but ValidE=0 forces every gated output to 0 regardless of CondExE.

Test Plan:
- Reset mid-stream: RegWD=1 flowing in E and M, assert reset one edge -> all outputs 0 next cycle, FlagsE=4'b0000.
- Condition pass: CondD=4'hE, RegWD=1, MemWD=0, CondExE=1 -> RegWriteM=1 at cycle+2, RegWriteW=1 at cycle+3.
- Condition fail: CondD=4'h0, MemWD=1, CondExE=0 -> MemWriteM=0; BranchD=1 with CondExE=0 -> BranchTakenE=0.
- Flags partial write: FlagWD=2'b10, ALUFlags=4'b0111, CondExE=1, start FlagsE=4'b0000 -> FlagsE=4'b0100 next cycle; then FlagWD=2'b01, ALUFlags=4'b1011 -> FlagsE=4'b0111.
- Stall: StallE=1 for 2 cycles with FlagWD=2'b11 in E -> E outputs held, RegWriteM=0 for 2 cycles, flags unchanged until StallE drops, then updated once.
- Flush and stall together: FlushE=1, StallE=1, RegWD=1 in D -> next cycle ALUControlE=0, CondE=0, PCSrcE=0, BranchTakenE=0 even with CondExE=1.
